// File: rtl/debugger_sequencer.sv
// ---------------------------------------------------------------------------
// debugger_sequencer
//
// Initiator side of the BE8 single-step debug access port. It takes one host
// debug request at a time and walks the 2-bit microcode STEP sequence, one
// step per clock, until the microcode raises PREADY or step 3 passes without
// it. The result goes back to the host as a single-cycle response strobe.
//
// Valid/ready semantics: a request transfers on a rising edge where
// req_valid && req_ready. req_ready is high only in IDLE and outside reset.
// The response side has no backpressure: rsp_valid is high for exactly one
// cycle, and rsp_rdata/rsp_err are valid in that cycle. Both hold their
// values until the next completion.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_ready              host request handshake
//   req_addr/req_write/req_wdata     host request payload
//   rsp_valid/rsp_rdata/rsp_err      host response (one-cycle strobe)
//   dbg_addr/dbg_write/dbg_step      to the microcode ROM
//   dbg_pready/dbg_paddr_or_pwdata   from the microcode ROM
//   bus_out/bus_oe/bus_in            shared computer bus
// ---------------------------------------------------------------------------
module debugger_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_write,
   output logic [1:0]        dbg_step,
   input  logic              dbg_pready,
   input  logic              dbg_paddr_or_pwdata,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   input  logic [DATA_W-1:0] bus_in
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        step_q;
   logic              accept;

   // State register. The async reset also drops bus_oe immediately, since
   // bus_oe is decoded from state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      dbg_step  = 2'd0;
      bus_oe    = 1'b0;
      bus_out   = '0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            // Held low while rst is asserted so no request is lost.
            req_ready = ~rst;
            accept    = req_valid & ~rst;
            if (accept) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            dbg_step = step_q;
            bus_oe   = dbg_write;
            // The microcode chooses between the address and write-data phases.
            if (dbg_paddr_or_pwdata) begin
               bus_out[ADDR_W-1:0] = dbg_addr;
            end else begin
               bus_out = wdata_q;
            end
            if (dbg_pready || (step_q == 2'd3)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request latch, step counter and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_addr  <= '0;
         dbg_write <= 1'b0;
         wdata_q   <= '0;
         step_q    <= 2'd0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            dbg_addr  <= req_addr;
            dbg_write <= req_write;
            wdata_q   <= req_wdata;
            step_q    <= 2'd0;
         end
         if (state_q == ACCESS) begin
            if (dbg_pready) begin
               // PREADY wins even on step 3: that is a success, not a timeout.
               rsp_rdata <= dbg_write ? '0 : bus_in;
               rsp_err   <= 1'b0;
            end else if (step_q == 2'd3) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b1;
            end else begin
               step_q <= step_q + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_debugger_sequencer.sv
// ---------------------------------------------------------------------------
// tb_debugger_sequencer
//
// Directed bench for debugger_sequencer. Inputs change on the falling edge;
// outputs are checked on the falling edge (or 1 ns after a combinational
// input change), well away from the rising edge. The microcode ROM is played
// by the bench: it sets dbg_pready/dbg_paddr_or_pwdata for each step.
// ---------------------------------------------------------------------------
module tb_debugger_sequencer;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_write;
  logic [1:0]        dbg_step;
  logic              dbg_pready;
  logic              dbg_paddr_or_pwdata;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_in;

  int checks = 0;
  int errors = 0;

  // Expected response read data, pushed when a request is issued.
  logic [DATA_W-1:0] exp_q[$];

  debugger_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_addr            (req_addr),
    .req_write           (req_write),
    .req_wdata           (req_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_rdata           (rsp_rdata),
    .rsp_err             (rsp_err),
    .dbg_addr            (dbg_addr),
    .dbg_write           (dbg_write),
    .dbg_step            (dbg_step),
    .dbg_pready          (dbg_pready),
    .dbg_paddr_or_pwdata (dbg_paddr_or_pwdata),
    .bus_out             (bus_out),
    .bus_oe              (bus_oe),
    .bus_in              (bus_in)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
  endtask

  // Compares a completion against the head of the expected queue.
  task automatic check_rsp(input string tag, input logic exp_err);
    logic [DATA_W-1:0] exp_d;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      exp_d = exp_q.pop_front();
      chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_d));
      chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_write = 1'b0;
    req_wdata = '0;
    dbg_pready = 1'b0;
    dbg_paddr_or_pwdata = 1'b0;
    bus_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_dbg_addr", 32'(dbg_addr), 32'd0);
    chk("rst_dbg_write", 32'(dbg_write), 32'd0);
    chk("rst_dbg_step", 32'(dbg_step), 32'd0);
    chk("rst_bus_out", 32'(bus_out), 32'd0);
    chk("rst_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Read, PREADY at step 1
    send(5'h0A, 1'b0, 8'h00);
    bus_in = 8'h5C;
    exp_q.push_back(8'h5C);
    tick();
    req_valid = 1'b0;
    chk("rd_step0", 32'(dbg_step), 32'd0);
    chk("rd_addr", 32'(dbg_addr), 32'h0A);
    chk("rd_write", 32'(dbg_write), 32'd0);
    chk("rd_oe0", 32'(bus_oe), 32'd0);
    chk("rd_ready0", 32'(req_ready), 32'd0);
    chk("rd_valid0", 32'(rsp_valid), 32'd0);
    tick();
    chk("rd_step1", 32'(dbg_step), 32'd1);
    chk("rd_oe1", 32'(bus_oe), 32'd0);
    dbg_pready = 1'b1;
    tick();
    dbg_pready = 1'b0;
    check_rsp("rd", 1'b0);
    chk("rd_done_step", 32'(dbg_step), 32'd0);
    chk("rd_done_ready", 32'(req_ready), 32'd0);
    chk("rd_done_oe", 32'(bus_oe), 32'd0);
    tick();
    chk("rd_idle_valid", 32'(rsp_valid), 32'd0);
    chk("rd_idle_ready", 32'(req_ready), 32'd1);
    chk("rd_hold_rdata", 32'(rsp_rdata), 32'h5C);

    // Write: address phase, data phase, PREADY at step 2; inputs change mid-access
    send(5'h13, 1'b1, 8'hA7);
    exp_q.push_back(8'h00);
    tick();
    req_valid = 1'b0;
    req_addr = 5'h1F;
    req_wdata = 8'h55;
    dbg_paddr_or_pwdata = 1'b1;
    #1;
    chk("wr_s0_step", 32'(dbg_step), 32'd0);
    chk("wr_s0_bus", 32'(bus_out), 32'h13);
    chk("wr_s0_oe", 32'(bus_oe), 32'd1);
    tick();
    dbg_paddr_or_pwdata = 1'b0;
    #1;
    chk("wr_s1_step", 32'(dbg_step), 32'd1);
    chk("wr_s1_bus", 32'(bus_out), 32'hA7);
    chk("wr_s1_oe", 32'(bus_oe), 32'd1);
    chk("wr_s1_addr", 32'(dbg_addr), 32'h13);
    tick();
    dbg_pready = 1'b1;
    chk("wr_s2_step", 32'(dbg_step), 32'd2);
    chk("wr_s2_bus", 32'(bus_out), 32'hA7);
    tick();
    dbg_pready = 1'b0;
    check_rsp("wr", 1'b0);
    chk("wr_done_oe", 32'(bus_oe), 32'd0);
    chk("wr_done_bus", 32'(bus_out), 32'd0);
    tick();
    chk("wr_idle_bus", 32'(bus_out), 32'd0);
    chk("wr_idle_addr", 32'(dbg_addr), 32'h13);
    chk("wr_idle_write", 32'(dbg_write), 32'd1);

    // Timeout: no PREADY in steps 0..3
    send(5'h07, 1'b0, 8'h00);
    bus_in = 8'hFF;
    exp_q.push_back(8'h00);
    tick();
    req_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("to_step%0d", s), 32'(dbg_step), 32'(s));
      chk($sformatf("to_valid%0d", s), 32'(rsp_valid), 32'd0);
      tick();
    end
    check_rsp("to", 1'b1);
    tick();
    chk("to_hold_err", 32'(rsp_err), 32'd1);

    // PREADY at step 3 is a success
    send(5'h02, 1'b0, 8'h00);
    bus_in = 8'h3C;
    exp_q.push_back(8'h3C);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("s3_step", 32'(dbg_step), 32'd3);
    dbg_pready = 1'b1;
    tick();
    dbg_pready = 1'b0;
    check_rsp("s3", 1'b0);
    tick();

    // Back-to-back with req_valid held high, PREADY at step 0
    send(5'h01, 1'b0, 8'h00);
    bus_in = 8'h11;
    dbg_pready = 1'b1;
    exp_q.push_back(8'h11);
    tick();                              // first accept
    req_addr = 5'h02;
    chk("bb1_addr", 32'(dbg_addr), 32'h01);
    chk("bb1_ready", 32'(req_ready), 32'd0);
    tick();
    check_rsp("bb1", 1'b0);
    chk("bb1_done_addr", 32'(dbg_addr), 32'h01);
    chk("bb1_done_ready", 32'(req_ready), 32'd0);
    bus_in = 8'h22;
    exp_q.push_back(8'h22);
    tick();
    chk("bb_idle_ready", 32'(req_ready), 32'd1);
    chk("bb_idle_addr", 32'(dbg_addr), 32'h01);
    tick();                              // second accept, 3 cycles later
    req_valid = 1'b0;
    chk("bb2_addr", 32'(dbg_addr), 32'h02);
    chk("bb2_step", 32'(dbg_step), 32'd0);
    tick();
    dbg_pready = 1'b0;
    check_rsp("bb2", 1'b0);
    tick();

    // Reset in the middle of a write at step 2
    send(5'h15, 1'b1, 8'h03);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("ra_step2", 32'(dbg_step), 32'd2);
    chk("ra_oe", 32'(bus_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("ra_oe_drop", 32'(bus_oe), 32'd0);
    chk("ra_step_drop", 32'(dbg_step), 32'd0);
    chk("ra_valid", 32'(rsp_valid), 32'd0);
    chk("ra_ready", 32'(req_ready), 32'd0);
    chk("ra_addr", 32'(dbg_addr), 32'd0);
    tick();
    chk("ra_valid_hold", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("ra_post_ready", 32'(req_ready), 32'd1);
    chk("ra_post_valid", 32'(rsp_valid), 32'd0);
    chk("ra_post_step", 32'(dbg_step), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debugger_sequencer.md
# debugger_sequencer

Initiator side of the BE8 single-step debug access port. It accepts one host debug request at a time (address, direction, write data) and walks the 2-bit microcode STEP sequence toward the debugger microcode ROM, one step per clock. It terminates on PREADY, drives the shared 8-bit computer bus with address or write data as the microcode selects, and returns read data or a timeout error to the host. It sits between the host-facing debug transport and the microcode decoder that drives the computer's control lines.

## Interface

Parameters:
- ADDR_W, 5, debug register address width; must match microcode ADDR.
- DATA_W, 8, computer bus width; ADDR_W ≤ DATA_W.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  host request present.
- req_ready  output  1  sequencer can accept a request.
- req_addr  input  ADDR_W  debug register address.
- req_write  input  1  1 = write, 0 = read.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle response strobe; no backpressure.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  access ended without PREADY; valid with rsp_valid.
- dbg_addr  output  ADDR_W  to microcode ADDR.
- dbg_write  output  1  to microcode WRITE.
- dbg_step  output  2  to microcode STEP.
- dbg_pready  input  1  microcode PREADY; combinational from addr/write/step.
- dbg_paddr_or_pwdata  input  1  microcode select: 1 = drive address, 0 = drive write data.
- bus_out  output  DATA_W  value driven onto computer bus.
- bus_oe  output  1  bus output enable.
- bus_in  input  DATA_W  computer bus sampled for reads.

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE: req_ready = 1. On req_valid && req_ready, latch req_addr/req_write/req_wdata into dbg_addr/dbg_write/wdata register, clear step counter, go to ACCESS.
- ACCESS: dbg_step = step counter. At each edge:
  - dbg_pready = 1: capture bus_in into rsp_rdata if read (0 if write), rsp_err = 0, go to DONE.
  - else if step = 3: rsp_rdata = 0, rsp_err = 1, go to DONE.
  - else increment step.
- DONE: rsp_valid = 1 for exactly this cycle, dbg_step = 0, bus_oe = 0, req_ready = 0; next edge to IDLE.
- Bus drive: bus_oe = 1 only in ACCESS with latched write = 1. bus_out = zero-extended dbg_addr when dbg_paddr_or_pwdata = 1, else latched wdata. In all other states bus_out = 0.
- dbg_addr/dbg_write hold their latched values through IDLE until the next accept. dbg_step = 0 outside ACCESS.
- req_* inputs are ignored outside the accept edge; changes during ACCESS do not affect the access in flight.

## Timing

- Reset (async assert, sync release): state IDLE; dbg_addr = 0, dbg_write = 0, dbg_step = 0, bus_out = 0, bus_oe = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0. req_ready is forced to 0 while rst = 1.
- Accept at edge E. Step s is presented in the cycle after E+s. PREADY at step s is sampled at edge E+s+1. rsp_valid is high in the cycle after E+s+1, and req_ready returns in the cycle after E+s+2.
- Minimum turnaround: PREADY at step 0 gives rsp_valid one cycle after the step-0 cycle. Back-to-back requests are spaced 3 cycles apart.
- Timeout: no PREADY in steps 0–3 gives rsp_err after exactly 4 ACCESS cycles.
- PREADY at step 3 is a success, not an error.
- rst mid-access: abort immediately. No rsp_valid is issued, bus_oe drops asynchronously, dbg_step = 0.
- rsp_rdata/rsp_err hold their values after DONE until the next completion.

## Test plan

- Reset: assert rst during ACCESS at step 2 -> bus_oe, dbg_step, rsp_valid = 0 immediately. After release, req_ready = 1 in IDLE.
- Read with PREADY at step 1: addr 5'h0A, write = 0, bus_in = 8'h5C -> dbg_step sequence 0, 1, then 0. rsp_valid for one cycle with rdata 8'h5C, err 0. bus_oe = 0 throughout.
- Write with address phase then data phase: addr 5'h13, wdata 8'hA7; microcode select = 1 at step 0, 0 at step 1, PREADY at step 2 -> bus_out 8'h13 then 8'hA7 with bus_oe = 1. rsp_valid with rdata 0, err 0.
- Timeout: PREADY held 0 -> steps 0, 1, 2, 3 each for one cycle. rsp_valid with err = 1, rdata = 0, exactly 4 cycles after the step-0 cycle.
- Back-to-back: req_valid held high with two requests, both PREADY at step 0 -> accepts spaced 3 cycles apart. The second request's inputs are ignored until req_ready re-asserts.
- Input stability: change req_addr/req_wdata during ACCESS -> dbg_addr and bus_out keep the latched values.
